lfsr_gen: RTL and testbench

//  Parametrised right-shifting LFSR: generalised width, taps, seed and feedback style.

---
 rtl/lfsr_pkg.sv | 35 +++
 rtl/lfsr_step.sv | 27 ++
 rtl/lfsr_gen.sv | 104 ++++++++++
 tb/tb_lfsr_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the generic next-state function.
package lfsr_pkg;

  // Widest state the generic next-state function supports.
  localparam int unsigned MaxWidth = 32;

  // Maximal-length tap masks (polynomial without its top term) and default seeds.
  localparam logic [7:0]  Taps8  = 8'h1D;         // x^8+x^4+x^3+x^2+1
  localparam logic [7:0]  Seed8  = 8'h01;
  localparam logic [15:0] Taps16 = 16'h6801;      // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] Seed16 = 16'h0001;
  localparam logic [31:0] Taps32 = 32'h0040_0007; // x^32+x^22+x^2+x^1+1
  localparam logic [31:0] Seed32 = 32'h0000_0001;

  // Right-shifting next state for a width-bit register held in the low bits of q.
  function automatic logic [MaxWidth-1:0] lfsr_nxt(input logic [MaxWidth-1:0] q,
                                                   input logic [MaxWidth-1:0] taps,
                                                   input int unsigned         width,
                                                   input logic                galois);
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] qm;
    logic [MaxWidth-1:0] nxt;
    logic                fb;
    mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
    qm   = q & mask;
    if (galois) begin
      nxt = (qm >> 1) ^ ({MaxWidth{qm[0]}} & taps);
    end else begin
      fb  = ^(qm & taps);
      nxt = (qm >> 1) | (MaxWidth'(fb) << (width - 1));
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational LFSR step: next value plus all-zero detect.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
  parameter bit               GALOIS = 1'b0
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             is_zero
);

  logic [MaxWidth-1:0] nxt_ext;
  logic                unused_nxt_hi;

  // Evaluate the shared next-state function on the zero-extended state.
  always_comb begin
    nxt_ext = lfsr_nxt(MaxWidth'(q), MaxWidth'(TAPS), WIDTH, GALOIS);
  end

  assign nxt           = nxt_ext[WIDTH-1:0];
  assign is_zero       = (q == '0);
  // Upper bits are always zero for narrow widths.
  assign unused_nxt_hi = ^nxt_ext;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with load, single step, burst runs and lock-up recovery.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = 8'h1D,
  parameter logic [WIDTH-1:0] SEED   = 8'h01,
  parameter bit               GALOIS = 1'b0,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] run_len,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             lockup_fix,
  output logic [CNT_W-1:0] step_cnt
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fix_q, fix_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] nxt;
  logic             is_zero;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .GALOIS(GALOIS)
  ) u_step (
    .q      (state_q),
    .nxt    (nxt),
    .is_zero(is_zero)
  );

  // Control priority: load > burst step > start > en; pulses default low.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fix_d   = 1'b0;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    if (load) begin
      state_d = din;
      cnt_d   = '0;
      busy_d  = 1'b0;
      rem_d   = '0;
    end else if (busy_q) begin
      state_d = is_zero ? SEED : nxt;
      fix_d   = is_zero;
      cnt_d   = cnt_q + CNT_W'(1);
      rem_d   = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      // Accept edge only latches the length; steps follow on later edges.
      rem_d  = run_len;
      busy_d = (run_len != '0);
      done_d = (run_len == '0);
    end else if (en) begin
      state_d = is_zero ? SEED : nxt;
      fix_d   = is_zero;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fix_q   <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fix_q   <= fix_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  assign dout       = state_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign lockup_fix = fix_q;
  assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen (Fibonacci and Galois instances).
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst, load, en, start;
  logic [7:0]  din;
  logic [15:0] run_len;
  logic [7:0]  dout;
  logic        busy, done, lockup_fix;
  logic [15:0] step_cnt;

  logic        g_rst, g_en;
  logic [7:0]  g_dout;
  logic        g_busy, g_done, g_fix;
  logic [15:0] g_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.GALOIS(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .en        (en),
    .start     (start),
    .run_len   (run_len),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .lockup_fix(lockup_fix),
    .step_cnt  (step_cnt)
  );

  lfsr_gen #(.GALOIS(1'b1)) dut_g (
    .clk       (clk),
    .rst       (g_rst),
    .load      (1'b0),
    .din       (8'h00),
    .en        (g_en),
    .start     (1'b0),
    .run_len   (16'd0),
    .dout      (g_dout),
    .busy      (g_busy),
    .done      (g_done),
    .lockup_fix(g_fix),
    .step_cnt  (g_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hits;
    rst = 1'b1; load = 1'b0; en = 1'b0; start = 1'b0; din = '0; run_len = '0;
    g_rst = 1'b1; g_en = 1'b0;
    tick();
    rst = 1'b0; g_rst = 1'b0;

    // 1: reset values and two single steps
    check_eq("rst_dout", dout, 8'h01);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_fix", lockup_fix, 1'b0);
    check_eq("rst_cnt", step_cnt, 16'd0);
    en = 1'b1;
    tick();
    check_eq("en1_dout", dout, 8'h80);
    tick();
    en = 1'b0;
    check_eq("en2_dout", dout, 8'h40);
    check_eq("en2_cnt", step_cnt, 16'd2);

    // 2: zero load then lock-up recovery
    load = 1'b1; din = 8'h00;
    tick();
    load = 1'b0;
    check_eq("ld0_dout", dout, 8'h00);
    check_eq("ld0_cnt", step_cnt, 16'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    check_eq("fix_dout", dout, 8'h01);
    check_eq("fix_pulse", lockup_fix, 1'b1);
    check_eq("fix_cnt", step_cnt, 16'd1);
    tick();
    check_eq("fix_low", lockup_fix, 1'b0);

    // 3: full-period burst
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; run_len = 16'd255;
    tick();
    start = 1'b0;
    n = 0; hits = 0;
    while (busy && n < 300) begin
      n++;
      if (n > 1 && dout == 8'h01) hits++;
      tick();
    end
    check_eq("per_busy_cycles", n, 255);
    check_eq("per_seed_hits", hits, 0);
    check_eq("per_done", done, 1'b1);
    check_eq("per_dout", dout, 8'h01);
    check_eq("per_cnt", step_cnt, 16'd255);
    tick();
    check_eq("per_done_low", done, 1'b0);

    // 4: zero-length burst
    start = 1'b1; run_len = 16'd0;
    tick();
    start = 1'b0;
    check_eq("z_done", done, 1'b1);
    check_eq("z_busy", busy, 1'b0);
    check_eq("z_dout", dout, 8'h01);
    tick();
    check_eq("z_done_low", done, 1'b0);
    check_eq("z_busy_low", busy, 1'b0);
    check_eq("z_cnt", step_cnt, 16'd255);

    // 5: load aborts a burst; en/start ignored while busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; run_len = 16'd10;
    tick();
    run_len = 16'd3; en = 1'b1;  // start stays high: must be ignored while busy
    check_eq("ab_busy", busy, 1'b1);
    tick();
    tick();
    tick();
    check_eq("ab_dout3", dout, 8'h20);
    check_eq("ab_cnt3", step_cnt, 16'd3);
    load = 1'b1; din = 8'h5A;
    tick();
    load = 1'b0; en = 1'b0; start = 1'b0;
    check_eq("ab_dout", dout, 8'h5A);
    check_eq("ab_busy0", busy, 1'b0);
    check_eq("ab_done", done, 1'b0);
    check_eq("ab_cnt", step_cnt, 16'd0);
    tick();
    check_eq("ab_done2", done, 1'b0);
    check_eq("ab_hold", dout, 8'h5A);

    // Reset mid-burst
    start = 1'b1; run_len = 16'd5;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rb_busy", busy, 1'b0);
    check_eq("rb_dout", dout, 8'h01);
    check_eq("rb_cnt", step_cnt, 16'd0);
    tick();
    check_eq("rb_done", done, 1'b0);

    // 6: Galois feedback
    g_rst = 1'b1;
    tick();
    g_rst = 1'b0;
    check_eq("g_rst", g_dout, 8'h01);
    g_en = 1'b1;
    tick();
    check_eq("g_step1", g_dout, 8'h1D);
    tick();
    g_en = 1'b0;
    check_eq("g_step2", g_dout, 8'h13);
    check_eq("g_cnt", g_cnt, 16'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
